hello_scroll_ctrl: RTL

Sequencer for the five-digit HELLO rotation display. Generates the 3-bit rotation select that the existing 5-to-1 rotation muxes and letter decoders consume, replacing the manual SW[2:0] selection with timed auto-scroll, pause, single-step, direction control and direct load. Sits between the board clock/keys and the display datapath; the datapath itself is unchanged.

---
 rtl/hello_pkg.sv | 41 ++++
 rtl/hello_scroll_ctrl_tick_prescaler.sv | 38 +++
 rtl/hello_scroll_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hello_pkg.sv
// Shared definitions for the HELLO rotation display: controller states,
// rotation-select limits, letter codes and the rotation step function.
package hello_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

    // Letter codes used by the display decoder; the controller rotates over them.
    localparam logic [SEL_W-1:0] H     = 3'd0;
    localparam logic [SEL_W-1:0] E     = 3'd1;
    localparam logic [SEL_W-1:0] L     = 3'd2;
    localparam logic [SEL_W-1:0] O     = 3'd3;
    localparam logic [SEL_W-1:0] BLANK = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // One rotation step in either direction; an out-of-range input recovers to 0.
    function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] sel,
                                                     input logic             rev);
        logic [SEL_W-1:0] nxt;
        if (sel > SEL_MAX) begin
            nxt = '0;
        end else if (rev) begin
            nxt = (sel == '0) ? SEL_MAX : sel - 3'd1;
        end else begin
            nxt = (sel == SEL_MAX) ? '0 : sel + 3'd1;
        end
        return nxt;
    endfunction

    // True when the step from sel in the given direction crosses the 4/0 seam.
    function automatic logic sel_wraps(input logic [SEL_W-1:0] sel,
                                       input logic             rev);
        return rev ? (sel == '0) : (sel == SEL_MAX);
    endfunction

endpackage

// File: rtl/hello_scroll_ctrl_tick_prescaler.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count; the count restarts on the same edge the tick is consumed.
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next count: clear has priority, otherwise count and wrap at the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// HELLO rotation sequencer: synchronizes the board controls, runs the
// IDLE/RUN/PAUSE state machine and owns the rotation select register.
module hello_scroll_ctrl
    import hello_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic             dir_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [SEL_W-1:0] load_val_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             step_tick_o,
    output logic             wrap_o,
    output logic             running_o
);

    logic             run_s1_q, run_s2_q;
    logic             dir_s1_q, dir_s2_q;
    logic             step_s1_q, step_s2_q, step_s3_q;
    logic             step_edge_q;
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_tick_q, step_tick_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;
    logic             advance;
    logic             tick;

    // Two-flop synchronizers for the asynchronous levels; a third STEP flop
    // and a registered edge flag give one pulse per STEP rising edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_s1_q    <= 1'b0;
            run_s2_q    <= 1'b0;
            dir_s1_q    <= 1'b0;
            dir_s2_q    <= 1'b0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_s3_q   <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            run_s1_q    <= run_i;
            run_s2_q    <= run_s1_q;
            dir_s1_q    <= dir_i;
            dir_s2_q    <= dir_s1_q;
            step_s1_q   <= step_i;
            step_s2_q   <= step_s1_q;
            step_s3_q   <= step_s2_q;
            step_edge_q <= step_s2_q & ~step_s3_q;
        end
    end

    // The prescaler only runs in RUN; LOAD restarts the scroll period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == RUN),
        .clr_i   (load_i || (state_q != RUN)),
        .tick_o  (tick)
    );

    // Next state, advance decision and registered-output next values.
    // A tick on the edge that leaves RUN is still honoured because it is
    // derived from the current state, not the next one.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_s2_q) begin
                    state_d = RUN;
                end else if (step_edge_q) begin
                    state_d = PAUSE;
                    advance = 1'b1;
                end
            end
            RUN: begin
                advance = tick;
                if (!run_s2_q) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                advance = step_edge_q;
                if (run_s2_q) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // LOAD wins: it freezes the state and swallows any coincident advance.
        if (load_i) begin
            state_d = state_q;
            advance = 1'b0;
        end

        if (load_i) begin
            sel_d = (load_val_i <= SEL_MAX) ? load_val_i : '0;
        end else if (advance) begin
            sel_d = sel_advance(sel_q, dir_s2_q);
        end else begin
            sel_d = (sel_q > SEL_MAX) ? '0 : sel_q;
        end

        step_tick_d = advance;
        wrap_d      = advance && sel_wraps(sel_q, dir_s2_q);
        running_d   = (state_d == RUN);
    end

    // State, rotation select and pulse outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            step_tick_q <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            step_tick_q <= step_tick_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
        end
    end

    assign sel_o       = sel_q;
    assign step_tick_o = step_tick_q;
    assign wrap_o      = wrap_q;
    assign running_o   = running_q;

endmodule
